// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with count enable,
// enable prescaler, synchronous clear, parallel load with range clamp,
// wrap or saturate behaviour at the range ends, and terminal-count and
// load-error event flags.
module updown_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD_VALUE = 16,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             tc_pulse,
  output logic             load_err
);

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 1..31");
  end
  if (MOD_VALUE < 2 || 64'(MOD_VALUE) > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("updown_mod_counter: MOD_VALUE must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_pre
    $error("updown_mod_counter: PRESCALE must be in 1..256");
  end

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MOD_VALUE - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(PRESCALE - 1);
  localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
  localparam logic             SAT_MODE  = (SATURATE != 0);

  logic [TW-1:0]    tick;
  logic [TW-1:0]    tick_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic             lerr_nxt;
  logic             step;

  // Next-state: clear beats load beats a prescaled count step.
  always_comb begin
    out_nxt  = out;
    tick_nxt = tick;
    tc_nxt   = 1'b0;
    lerr_nxt = 1'b0;
    step     = 1'b0;
    if (clr) begin
      out_nxt  = '0;
      tick_nxt = '0;
    end else if (load) begin
      tick_nxt = '0;
      if (load_val > MAXV) begin
        out_nxt  = MAXV;
        lerr_nxt = 1'b1;
      end else begin
        out_nxt = load_val;
      end
    end else if (en) begin
      if (tick == TICK_LAST) begin
        tick_nxt = '0;
        step     = 1'b1;
      end else begin
        tick_nxt = tick + TICK_ONE;
      end
    end

    if (step) begin
      if (up_dn) begin
        if (out == MAXV) begin
          tc_nxt  = 1'b1;
          out_nxt = SAT_MODE ? out : '0;
        end else begin
          out_nxt = out + ONE;
        end
      end else begin
        if (out == '0) begin
          tc_nxt  = 1'b1;
          out_nxt = SAT_MODE ? out : MAXV;
        end else begin
          out_nxt = out - ONE;
        end
      end
    end
  end

  // State and event-flag registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      tick     <= '0;
      tc_pulse <= 1'b0;
      load_err <= 1'b0;
    end else begin
      out      <= out_nxt;
      tick     <= tick_nxt;
      tc_pulse <= tc_nxt;
      load_err <= lerr_nxt;
    end
  end

  // Range-end indicators follow the registered count directly.
  always_comb begin
    at_max = (out == MAXV);
    at_min = (out == '0);
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Testbench for updown_mod_counter: four parameterisations share one stimulus
// stream; a reference model feeds a scoreboard queue every cycle, and a
// vector table plus hand sequences add hard-coded expectations.
module tb_updown_mod_counter;

  logic       clk, rst, en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] o [4];
  logic [3:0] am, an, tc, le;

  // 0: M10 wrap P1, 1: M10 sat P1, 2: M10 wrap P3, 3: M16 wrap P1
  int MODV [4] = '{10, 10, 10, 16};
  int SATV [4] = '{0, 1, 0, 0};
  int PREV [4] = '{1, 1, 3, 1};

  updown_mod_counter #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(0), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(o[0]), .at_max(am[0]), .at_min(an[0]),
    .tc_pulse(tc[0]), .load_err(le[0]));
  updown_mod_counter #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(1), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(o[1]), .at_max(am[1]), .at_min(an[1]),
    .tc_pulse(tc[1]), .load_err(le[1]));
  updown_mod_counter #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(0), .PRESCALE(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(o[2]), .at_max(am[2]), .at_min(an[2]),
    .tc_pulse(tc[2]), .load_err(le[2]));
  updown_mod_counter #(.WIDTH(4), .MOD_VALUE(16), .SATURATE(0), .PRESCALE(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(o[3]), .at_max(am[3]), .at_min(an[3]),
    .tc_pulse(tc[3]), .load_err(le[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int o; bit am; bit an; bit tc; bit le;
  } exp_t;

  typedef struct {
    bit en; bit up; bit clr; bit load; int lv;
    int exp_o; bit exp_tc; bit exp_le;
  } vec_t;

  exp_t q[$];
  int   mo [4];
  int   mt [4];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mo[k] = 0;
      mt[k] = 0;
    end
  endtask

  // Reference behaviour for one counter instance over one clock edge.
  task automatic model_step(input int k);
    exp_t e;
    int   m;
    bit   s;
    m = MODV[k];
    s = 1'b0;
    e.tc = 1'b0;
    e.le = 1'b0;
    if (clr) begin
      mo[k] = 0;
      mt[k] = 0;
    end else if (load) begin
      mt[k] = 0;
      if (int'(load_val) >= m) begin
        mo[k] = m - 1;
        e.le  = 1'b1;
      end else begin
        mo[k] = int'(load_val);
      end
    end else if (en) begin
      mt[k] = mt[k] + 1;
      if (mt[k] == PREV[k]) begin
        mt[k] = 0;
        s = 1'b1;
      end
    end
    if (s && up_dn) begin
      if (mo[k] == m - 1) begin
        e.tc = 1'b1;
        if (SATV[k] == 0) mo[k] = 0;
      end else mo[k] = mo[k] + 1;
    end else if (s) begin
      if (mo[k] == 0) begin
        e.tc = 1'b1;
        if (SATV[k] == 0) mo[k] = m - 1;
      end else mo[k] = mo[k] - 1;
    end
    e.o  = mo[k];
    e.am = (mo[k] == m - 1);
    e.an = (mo[k] == 0);
    q.push_back(e);
  endtask

  // Push expectations for the coming edge, take the edge, then compare.
  task automatic step();
    exp_t e;
    for (int k = 0; k < 4; k++) model_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      e = q.pop_front();
      check($sformatf("sb%0d.out", k), int'(o[k]), e.o);
      check($sformatf("sb%0d.at_max", k), int'(am[k]), int'(e.am));
      check($sformatf("sb%0d.at_min", k), int'(an[k]), int'(e.an));
      check($sformatf("sb%0d.tc", k), int'(tc[k]), int'(e.tc));
      check($sformatf("sb%0d.lerr", k), int'(le[k]), int'(e.le));
    end
  endtask

  task automatic drive(input bit e_, input bit u_, input bit c_, input bit l_, input int v_);
    en = e_; up_dn = u_; clr = c_; load = l_; load_val = 4'(v_);
  endtask

  vec_t vt [18];
  int   pre_exp [6] = '{0, 0, 1, 1, 1, 2};

  initial begin
    // Vector table for instance 0 (MOD 10, wrap, PRESCALE 1), from reset.
    for (int i = 0; i < 9; i++) vt[i] = '{1, 1, 0, 0, 0, i + 1, 0, 0};
    vt[9]  = '{1, 1, 0, 0, 0,  0, 1, 0};
    vt[10] = '{1, 0, 0, 0, 0,  9, 1, 0};
    vt[11] = '{1, 0, 0, 0, 0,  8, 0, 0};
    vt[12] = '{0, 1, 0, 1, 6,  6, 0, 0};
    vt[13] = '{0, 1, 0, 1, 12, 9, 0, 1};
    vt[14] = '{0, 1, 0, 0, 0,  9, 0, 0};
    vt[15] = '{0, 1, 1, 1, 5,  0, 0, 0};
    vt[16] = '{1, 1, 0, 1, 6,  6, 0, 0};
    vt[17] = '{1, 1, 0, 0, 0,  7, 0, 0};

    rst = 1'b1;
    drive(0, 1, 0, 0, 0);
    model_reset();
    #12;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst%0d.out", k), int'(o[k]), 0);
      check($sformatf("rst%0d.at_min", k), int'(an[k]), 1);
      check($sformatf("rst%0d.at_max", k), int'(am[k]), 0);
      check($sformatf("rst%0d.flags", k), int'({tc[k], le[k]}), 0);
    end
    #1 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].en, vt[i].up, vt[i].clr, vt[i].load, vt[i].lv);
      step();
      check($sformatf("vec%0d.out", i), int'(o[0]), vt[i].exp_o);
      check($sformatf("vec%0d.tc", i), int'(tc[0]), int'(vt[i].exp_tc));
      check($sformatf("vec%0d.lerr", i), int'(le[0]), int'(vt[i].exp_le));
      if (vt[i].exp_o == 9) check($sformatf("vec%0d.at_max", i), int'(am[0]), 1);
    end

    // Saturate: three up steps at the top hold the value, pulsing each time.
    drive(0, 1, 0, 1, 9);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      step();
      check($sformatf("sat%0d.out", i), int'(o[1]), 9);
      check($sformatf("sat%0d.tc", i), int'(tc[1]), 1);
    end
    drive(0, 1, 0, 0, 0);
    step();
    check("sat.tc_drop", int'(tc[1]), 0);

    // Prescale by 3, then an enable gap that must not disturb the period.
    drive(0, 1, 1, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0, 0);
      step();
      check($sformatf("pre%0d.out", i), int'(o[2]), pre_exp[i]);
    end
    drive(1, 1, 0, 0, 0);
    step();
    check("pre.gap_start", int'(o[2]), 2);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0);
      step();
      check($sformatf("pre.gap%0d", i), int'(o[2]), 2);
    end
    drive(1, 1, 0, 0, 0);
    step();
    check("pre.resume1", int'(o[2]), 2);
    step();
    check("pre.resume2", int'(o[2]), 3);
    check("pre.resume2.tc", int'(tc[2]), 0);

    // Full binary range: natural roll-over in both directions.
    drive(0, 1, 0, 1, 15);
    step();
    check("full.load15", int'(o[3]), 15);
    check("full.load15.at_max", int'(am[3]), 1);
    drive(1, 1, 0, 0, 0);
    step();
    check("full.up_roll", int'(o[3]), 0);
    check("full.up_roll.tc", int'(tc[3]), 1);
    drive(1, 0, 0, 0, 0);
    step();
    check("full.dn_roll", int'(o[3]), 15);
    check("full.dn_roll.tc", int'(tc[3]), 1);
    drive(0, 0, 0, 0, 0);
    step();
    check("full.tc_drop", int'(tc[3]), 0);

    // Asynchronous reset between edges with a count of 7 in flight.
    drive(0, 1, 0, 1, 7);
    step();
    check("arst.pre", int'(o[0]), 7);
    drive(1, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("arst%0d.out", k), int'(o[k]), 0);
      check($sformatf("arst%0d.flags", k), int'({tc[k], le[k]}), 0);
    end
    model_reset();
    #1 rst = 1'b0;
    step();
    check("arst.first_step", int'(o[0]), 1);
    check("arst.pre3_hold", int'(o[2]), 0);
    step();
    step();
    check("arst.pre3_step", int'(o[2]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
